lcd_cmd_arbiter: RTL and testbench

// - Shares one lcd_ctrl instance between two host requesters (ID 0/1): round-robin grant,
//   one-cycle command issue, 25-byte image-load streaming, return of the 9-pixel window.
// - Sits between the host-side request ports and the lcd_ctrl cmd/datain/busy/dataout pins.
// - Exactly one transaction is in flight at a time; the arbiter owns lcd_ctrl until DONE.

---
 rtl/lcd_cmd_arbiter.sv | 152 +++++++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin owner of one lcd_ctrl for two requesters: issue, optional 25-byte load, 9-beat window return.
// Owner is chosen in IDLE only when lcd_busy is low; once granted the transaction runs to DONE (or timeout).
module lcd_cmd_arbiter #(
  parameter int DW      = 8,
  parameter int IMG_PIX = 25,
  parameter int OUT_PIX = 9,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [2:0]    req_cmd0,
  input  logic [2:0]    req_cmd1,
  input  logic [DW-1:0] load_data0,
  input  logic [DW-1:0] load_data1,
  output logic [1:0]    grant,
  output logic [1:0]    load_rd,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_valid,
  output logic [1:0]    done,
  output logic          err,
  output logic [2:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic [DW-1:0] lcd_datain,
  input  logic          lcd_busy,
  input  logic [DW-1:0] lcd_dataout,
  input  logic          lcd_output_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [4:0]      load_cnt_q, load_cnt_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [5:0]      to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= 3'd0;
      load_cnt_q   <= 5'd0;
      beat_cnt_q   <= 4'd0;
      to_cnt_q     <= 6'd0;
      timeout_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      load_cnt_q   <= load_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    load_cnt_d   = load_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    to_cnt_d     = to_cnt_q;
    timeout_d    = timeout_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!lcd_busy && req != 2'b00) begin
          // Contention alternates away from the previous owner; a lone request wins outright.
          owner_d    = (req == 2'b11) ? ~last_grant_q : req[1];
          cmd_d      = owner_d ? req_cmd1 : req_cmd0;
          load_cnt_d = 5'd0;
          beat_cnt_d = 4'd0;
          to_cnt_d   = 6'd0;
          timeout_d  = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = (cmd_q == 3'd0) ? S_LOAD : S_WAIT;
      S_LOAD: begin
        if (load_cnt_q == 5'(IMG_PIX - 1)) state_d = S_WAIT;
        else load_cnt_d = load_cnt_q + 5'd1;
      end
      S_WAIT: begin
        if (lcd_output_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = lcd_dataout;
          to_cnt_d    = 6'd0;
          beat_cnt_d  = beat_cnt_q + 4'd1;
          if (beat_cnt_q == 4'(OUT_PIX - 1)) state_d = S_DONE;
        end else if (to_cnt_q == 6'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant         = 2'b00;
    load_rd       = 2'b00;
    done          = 2'b00;
    err           = 1'b0;
    lcd_cmd_valid = 1'b0;
    lcd_datain    = '0;
    if (state_q != S_IDLE) grant = owner_q ? 2'b10 : 2'b01;
    case (state_q)
      S_ISSUE: lcd_cmd_valid = 1'b1;
      S_LOAD: begin
        load_rd    = owner_q ? 2'b10 : 2'b01;
        lcd_datain = owner_q ? load_data1 : load_data0;
      end
      S_DONE: begin
        done = owner_q ? 2'b10 : 2'b01;
        err  = timeout_q;
      end
      default: ;
    endcase
  end

  assign lcd_cmd   = cmd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: behavioural lcd_ctrl stub plus requesters, with a scoreboard of grants, beats and completions.
module tb_lcd_cmd_arbiter;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [2:0]    req_cmd0, req_cmd1;
  logic [DW-1:0] load_data0, load_data1;
  logic [1:0]    grant, load_rd, done;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid, err;
  logic [2:0]    lcd_cmd;
  logic          lcd_cmd_valid;
  logic [DW-1:0] lcd_datain, lcd_dataout;
  logic          lcd_busy, lcd_output_valid;

  lcd_cmd_arbiter #(.DW(DW), .IMG_PIX(25), .OUT_PIX(9), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .load_data0(load_data0), .load_data1(load_data1), .grant(grant), .load_rd(load_rd),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .done(done), .err(err),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] exp_beats[$];
  logic [2:0] exp_done[$];
  logic [1:0] exp_grant[$];

  // environment state
  int         es;
  int         pend0, pend1;
  logic [7:0] base0, base1;
  bit         stuck, stray;
  logic [2:0] cur_cmd, seen_cmd;
  logic       cur_owner;
  logic [7:0] sum;
  int         idx, k, load_pulses, bad_rd, stuck_cnt;

  // monitor state
  int          mon_cyc = 0;
  int          last_done_cyc = 0;
  int          last_gap = 0;
  int          rsp_seen = 0;
  logic [1:0]  prev_grant = 2'b00;
  logic [31:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_txn(input int id, input logic [2:0] cmd, input logic [7:0] base, input bit to);
    logic [7:0] s;
    logic [1:0] oh;
    s  = (cmd == 3'd0) ? 8'(25 * int'(base) + 300) : 8'd0;
    oh = (id == 0) ? 2'b01 : 2'b10;
    exp_grant.push_back(oh);
    if (!to) for (int kk = 0; kk < 9; kk++) exp_beats.push_back({1'b0, cmd, 4'b0} + 8'(kk) + s);
    exp_done.push_back({oh, to});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(pend0 == 0 && pend1 == 0 && es == 0 && grant == 2'b00) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < 3000), 32'd1);
    chk({tag, "_queues_drained"}, 32'(exp_beats.size() + exp_done.size() + exp_grant.size()), 32'd0);
  endtask

  // lcd_ctrl stub and requester data/level drivers, all updated on the falling edge
  initial begin
    es = 0; req = 2'b00; lcd_busy = 1'b0; lcd_output_valid = 1'b0; lcd_dataout = '0;
    load_data0 = '0; load_data1 = '0; cur_cmd = 3'd0; seen_cmd = 3'd0; cur_owner = 1'b0;
    sum = 8'd0; idx = 0; k = 0; load_pulses = 0; bad_rd = 0; stuck_cnt = 0;
    forever begin
      @(negedge clk);
      if (done[0] && pend0 > 0) pend0--;
      if (done[1] && pend1 > 0) pend1--;
      req = {pend1 != 0, pend0 != 0};
      if (!reset) begin
        es = 0; lcd_busy = 1'b0; lcd_output_valid = 1'b0;
      end else begin
        case (es)
          0: begin
            lcd_output_valid = 1'b0;
            if (lcd_cmd_valid) begin
              lcd_busy = 1'b1; cur_cmd = lcd_cmd; seen_cmd = lcd_cmd; cur_owner = grant[1];
              sum = 8'd0; idx = 0; k = 0; load_pulses = 0; bad_rd = 0; stuck_cnt = 0;
              load_data0 = base0; load_data1 = base1;
              es = (lcd_cmd == 3'd0) ? 1 : (stuck ? 3 : 2);
            end else if (stray) begin
              lcd_output_valid = 1'b1; lcd_dataout = 8'hA5; stray = 1'b0;
            end
          end
          1: begin
            if (load_rd == (cur_owner ? 2'b10 : 2'b01)) load_pulses++;
            else bad_rd++;
            sum = sum + lcd_datain;
            idx++;
            if (cur_owner) load_data1 = base1 + 8'(idx);
            else load_data0 = base0 + 8'(idx);
            if (idx == 25) es = 2;
          end
          2: begin
            if (k < 9) begin
              lcd_output_valid = 1'b1;
              lcd_dataout = {1'b0, cur_cmd, 4'b0} + 8'(k) + sum;
              k++;
            end else begin
              lcd_output_valid = 1'b0; lcd_busy = 1'b0; es = 0;
            end
          end
          default: begin
            lcd_output_valid = 1'b0;
            if (done != 2'b00) begin
              lcd_busy = 1'b0; es = 0;
            end else stuck_cnt++;
          end
        endcase
      end
    end
  end

  // scoreboard consumer
  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!reset) prev_grant = 2'b00;
      else begin
        if (rsp_valid) begin
          rsp_seen++;
          if (exp_beats.size() != 0) mon_e = 32'(exp_beats.pop_front());
          else mon_e = 32'hDEAD_BEEF;
          chk("rsp_data", 32'(rsp_data), mon_e);
        end
        if (done != 2'b00 || err) begin
          last_done_cyc = mon_cyc;
          if (exp_done.size() != 0) mon_e = 32'(exp_done.pop_front());
          else mon_e = 32'hDEAD_BEEF;
          chk("done_err", 32'({done, err}), mon_e);
        end
        if (grant != 2'b00 && prev_grant == 2'b00) begin
          last_gap = mon_cyc - last_done_cyc;
          if (exp_grant.size() != 0) mon_e = 32'(exp_grant.pop_front());
          else mon_e = 32'hDEAD_BEEF;
          chk("grant_order", 32'(grant), mon_e);
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s;
    reset = 1'b0; req_cmd0 = 3'd0; req_cmd1 = 3'd0; base0 = 8'd0; base1 = 8'd0;
    pend0 = 0; pend1 = 0; stuck = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ctrl_outs", 32'({load_rd, done, err, rsp_valid, lcd_cmd_valid, lcd_cmd}), 32'd0);
    chk("rst_data_outs", 32'({rsp_data, lcd_datain}), 32'd0);
    reset = 1'b1;

    // image load from requester 0, bytes 0..24
    base0 = 8'd0; req_cmd0 = 3'd0;
    push_txn(0, 3'd0, 8'd0, 1'b0);
    pend0 = 1;
    wait_idle("load");
    chk("load_pulses", 32'(load_pulses), 32'd25);
    chk("load_wrong_rd", 32'(bad_rd), 32'd0);

    // both request right after reset: 0 first, then 1 with a single idle cycle
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_cmd0 = 3'd1; req_cmd1 = 3'd1;
    push_txn(0, 3'd1, 8'd0, 1'b0);
    push_txn(1, 3'd1, 8'd0, 1'b0);
    pend0 = 1; pend1 = 1;
    wait_idle("rr_both");
    chk("rr_gap_cycles", 32'(last_gap), 32'd2);

    // three requests from 0 against two from 1: strict alternation
    req_cmd0 = 3'd2; req_cmd1 = 3'd3;
    push_txn(0, 3'd2, 8'd0, 1'b0);
    push_txn(1, 3'd3, 8'd0, 1'b0);
    push_txn(0, 3'd2, 8'd0, 1'b0);
    push_txn(1, 3'd3, 8'd0, 1'b0);
    push_txn(0, 3'd2, 8'd0, 1'b0);
    pend0 = 3; pend1 = 2;
    wait_idle("alternate");

    // stray output_valid while idle must not reach rsp_valid
    s = rsp_seen;
    stray = 1'b1;
    repeat (6) @(negedge clk);
    chk("stray_sent", 32'(stray), 32'd0);
    chk("stray_dropped", 32'(rsp_seen - s), 32'd0);

    // no window beats: timeout after 63 WAIT cycles
    stuck = 1'b1; req_cmd1 = 3'd2;
    push_txn(1, 3'd2, 8'd0, 1'b1);
    pend1 = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 2'b00 && n < 500);
    chk("timeout_in_time", 32'(n < 500), 32'd1);
    chk("timeout_wait_cycles", 32'(stuck_cnt), 32'd63);
    @(negedge clk);
    chk("timeout_back_idle", 32'({grant, lcd_cmd_valid, load_rd}), 32'd0);
    stuck = 1'b0;
    wait_idle("timeout");

    // undefined command forwarded unchanged
    req_cmd1 = 3'd7;
    push_txn(1, 3'd7, 8'd0, 1'b0);
    pend1 = 1;
    wait_idle("cmd7");
    chk("cmd7_forwarded", 32'(seen_cmd), 32'd7);
    chk("cmd_holds_after", 32'(lcd_cmd), 32'd7);

    // requester 0 transaction so that last owner is 0 before the reset test
    base1 = 8'd40; req_cmd0 = 3'd4;
    push_txn(0, 3'd4, 8'd0, 1'b0);
    pend0 = 1;
    wait_idle("pre_reset");

    // reset in the 10th LOAD cycle
    req_cmd0 = 3'd0; base0 = 8'd5;
    exp_grant.push_back(2'b01);
    pend0 = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_cmd_valid && n < 100);
    chk("rst_issue_seen", 32'(lcd_cmd_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("rst_still_loading", 32'(load_rd), 32'd1);
    #1;
    reset = 1'b0; pend0 = 0; pend1 = 0;
    #1;
    chk("rst_mid_all_zero",
        32'({grant, load_rd, done, err, rsp_valid, lcd_cmd_valid, lcd_cmd, lcd_datain, rsp_data}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req_cmd0 = 3'd1; req_cmd1 = 3'd1;
    push_txn(0, 3'd1, 8'd0, 1'b0);
    push_txn(1, 3'd1, 8'd0, 1'b0);
    pend0 = 1; pend1 = 1;
    wait_idle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
